// File: rtl/block_assembler_if.sv
// Byte-in / block-out handshake bundle for block_assembler.
// slave: the assembler itself; master: the byte source plus the block consumer.
interface block_assembler_if;
    logic [7:0]   in_byte;
    logic         in_valid;
    logic         in_ready;
    logic         flush;
    logic [127:0] block_out;
    logic         block_valid;
    logic         block_ready;
    logic [4:0]   byte_count;

    modport master (
        output in_byte, in_valid, flush, block_ready,
        input  in_ready, block_out, block_valid, byte_count
    );

    modport slave (
        input  in_byte, in_valid, flush, block_ready,
        output in_ready, block_out, block_valid, byte_count
    );
endinterface

// File: rtl/block_assembler.sv
// block_assembler: packs 16 handshaked bytes into a 128-bit block and holds it
// until the downstream serializer takes it. Byte k is stored in lane register k;
// LSB_FIRST only changes how lanes are mapped onto block_out.
// Optional feature macro: BLOCK_ASM_FLUSH_EN (flush closes a partial block and
// pads the unwritten lanes with PAD_BYTE). Without it, flush has no effect.
module block_assembler #(
    parameter bit         LSB_FIRST = 1'b1,
    parameter logic [7:0] PAD_BYTE  = 8'h00
) (
    input  logic              clock,
    input  logic              reset,
    block_assembler_if.slave  bus
);
    typedef enum logic {S_FILL = 1'b0, S_FULL = 1'b1} state_t;

    state_t       r_state;
    state_t       w_state_next;
    logic [4:0]   r_count;
    logic [4:0]   w_count_next;
    logic [7:0]   r_lanes     [16];
    logic [7:0]   w_lane_next [16];
    logic         w_in_ready;
    logic         w_block_valid;
    logic         w_in_fire;
    logic         w_out_fire;
    logic         w_flush_close;
    wire  [127:0] w_block_out;

    assign w_in_fire  = bus.in_valid & w_in_ready;
    assign w_out_fire = w_block_valid & bus.block_ready;

`ifdef BLOCK_ASM_FLUSH_EN
    // Close early only if the block would contain at least one real byte.
    assign w_flush_close = (r_state == S_FILL) & bus.flush & ((r_count != 5'd0) | w_in_fire);
`else
    // Port kept for a uniform interface; a block closes only on its 16th byte.
    assign w_flush_close = bus.flush & 1'b0;
`endif

    // State register.
    always_ff @(posedge clock) begin
        if (reset) begin
            r_state <= S_FILL;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Next state: 16th byte or flush closes the block; out_fire reopens it.
    always_comb begin
        w_state_next = r_state;
        case (r_state)
            S_FILL: if (w_flush_close || (w_in_fire && (r_count == 5'd15))) w_state_next = S_FULL;
            S_FULL: if (w_out_fire) w_state_next = S_FILL;
            default: w_state_next = S_FILL;
        endcase
    end

    // Handshake outputs: while full, a new byte is only taken when the block leaves.
    always_comb begin
        w_in_ready    = 1'b1;
        w_block_valid = 1'b0;
        if (r_state == S_FULL) begin
            w_in_ready    = bus.block_ready;
            w_block_valid = 1'b1;
        end
    end

    // Fill count: frozen at 16 while full; restarts at 0 or 1 when the block leaves.
    always_comb begin
        w_count_next = r_count;
        if (r_state == S_FILL) begin
            if (w_flush_close) begin
                w_count_next = 5'd16;
            end else if (w_in_fire) begin
                w_count_next = r_count + 5'd1;
            end
        end else if (w_out_fire) begin
            w_count_next = w_in_fire ? 5'd1 : 5'd0;
        end
    end

    // Per-lane update and lane-to-output mapping.
    // In FULL an in_fire implies out_fire, so the new byte goes to lane 0 of a fresh block.
    genvar gi;
    generate
        for (gi = 0; gi < 16; gi++) begin : g_lane
            localparam logic [4:0] IDX = 5'(gi);
            localparam int         POS = LSB_FIRST ? gi : 15 - gi;
            wire w_take;

            assign w_take = w_in_fire & ((r_state == S_FILL) ? (r_count == IDX) : (IDX == 5'd0));

            assign w_lane_next[gi] =
                w_take                 ? bus.in_byte :
                (r_state == S_FILL)    ? ((w_flush_close && (r_count <= IDX)) ? PAD_BYTE : r_lanes[gi]) :
                w_out_fire             ? 8'h00 : r_lanes[gi];

            assign w_block_out[8*POS +: 8] = r_lanes[gi];
        end
    endgenerate

    // Datapath registers: reset discards any partial block.
    always_ff @(posedge clock) begin
        if (reset) begin
            r_count <= 5'd0;
            for (int k = 0; k < 16; k++) r_lanes[k] <= 8'h00;
        end else begin
            r_count <= w_count_next;
            for (int k = 0; k < 16; k++) r_lanes[k] <= w_lane_next[k];
        end
    end

    assign bus.in_ready    = w_in_ready;
    assign bus.block_valid = w_block_valid;
    assign bus.block_out   = w_block_out;
    assign bus.byte_count  = r_count;
endmodule

// File: tb/tb_block_assembler.sv
// Bench for block_assembler: directed scenarios plus a random handshake run,
// with expected blocks queued when bytes are driven and popped when a block leaves.
module tb_block_assembler;
    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    block_assembler_if ifa ();
    block_assembler_if ifb ();

    block_assembler #(.LSB_FIRST(1'b1), .PAD_BYTE(8'h20)) dut_a (.clock(clk), .reset(rst), .bus(ifa));
    block_assembler #(.LSB_FIRST(1'b0), .PAD_BYTE(8'h20)) dut_b (.clock(clk), .reset(rst), .bus(ifb));

    int            n_checks = 0;
    int            n_pass   = 0;
    logic [127:0]  q_exp [$];
    logic [127:0]  exp_blk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        ifa.in_valid = 1'b0; ifa.in_byte = 8'h00; ifa.flush = 1'b0; ifa.block_ready = 1'b1;
        ifb.in_valid = 1'b0; ifb.in_byte = 8'h00; ifb.flush = 1'b0; ifb.block_ready = 1'b1;
        q_exp.delete();
        tick();
        rst = 1'b0;
    endtask

    task automatic test_reset();
        do_reset();
        tick();
        @(negedge clk);
        n_checks++; if (ifa.byte_count !== 5'd0) $display("FAIL reset_count: got %0d want 0", ifa.byte_count); else n_pass++;
        n_checks++; if (ifa.block_valid !== 1'b0) $display("FAIL reset_valid: got %b want 0", ifa.block_valid); else n_pass++;
        n_checks++; if (ifa.block_out !== 128'h0) $display("FAIL reset_out: got %h want 0", ifa.block_out); else n_pass++;
        n_checks++; if (ifa.in_ready !== 1'b1) $display("FAIL reset_in_ready: got %b want 1", ifa.in_ready); else n_pass++;
        tick();
    endtask

    task automatic test_back_to_back();
        bit rdy_ok;
        rdy_ok = 1'b1;
        do_reset();
        exp_blk = '0;
        for (int i = 0; i < 16; i++) begin
            ifa.in_valid = 1'b1;
            ifa.in_byte  = 8'(i);
            exp_blk[8*i +: 8] = 8'(i);
            @(negedge clk);
            if (ifa.in_ready !== 1'b1) rdy_ok = 1'b0;
            tick();
        end
        q_exp.push_back(exp_blk);
        ifa.in_byte = 8'h55;
        @(negedge clk);
        n_checks++; if (rdy_ok !== 1'b1) $display("FAIL b2b_in_ready_fill: dropped=%b want never", !rdy_ok); else n_pass++;
        n_checks++; if (ifa.in_ready !== 1'b1) $display("FAIL b2b_in_ready_full: got %b want 1", ifa.in_ready); else n_pass++;
        n_checks++; if (ifa.block_valid !== 1'b1) $display("FAIL b2b_valid: got %b want 1", ifa.block_valid); else n_pass++;
        n_checks++; if (ifa.byte_count !== 5'd16) $display("FAIL b2b_count16: got %0d want 16", ifa.byte_count); else n_pass++;
        exp_blk = q_exp.pop_front();
        n_checks++; if (ifa.block_out !== exp_blk) $display("FAIL b2b_block: got %h want %h", ifa.block_out, exp_blk); else n_pass++;
        tick();
        ifa.in_valid = 1'b0;
        @(negedge clk);
        n_checks++; if (ifa.block_valid !== 1'b0) $display("FAIL b2b_valid_one_cycle: got %b want 0", ifa.block_valid); else n_pass++;
        n_checks++; if (ifa.byte_count !== 5'd1) $display("FAIL b2b_nobubble_count: got %0d want 1", ifa.byte_count); else n_pass++;
        n_checks++; if (ifa.block_out !== 128'h55) $display("FAIL b2b_nobubble_lane0: got %h want 55", ifa.block_out); else n_pass++;
        tick();
    endtask

    task automatic test_backpressure();
        do_reset();
        ifa.block_ready = 1'b0;
        exp_blk = '0;
        for (int i = 0; i < 16; i++) begin
            ifa.in_valid = 1'b1;
            ifa.in_byte  = 8'h10 + 8'(i);
            exp_blk[8*i +: 8] = 8'h10 + 8'(i);
            tick();
        end
        q_exp.push_back(exp_blk);
        ifa.in_byte = 8'hAA;
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            n_checks++; if (ifa.block_valid !== 1'b1) $display("FAIL bp_valid_held c%0d: got %b want 1", c, ifa.block_valid); else n_pass++;
            n_checks++; if (ifa.block_out !== q_exp[0]) $display("FAIL bp_block_stable c%0d: got %h want %h", c, ifa.block_out, q_exp[0]); else n_pass++;
            n_checks++; if (ifa.in_ready !== 1'b0) $display("FAIL bp_in_ready c%0d: got %b want 0", c, ifa.in_ready); else n_pass++;
            n_checks++; if (ifa.byte_count !== 5'd16) $display("FAIL bp_count c%0d: got %0d want 16", c, ifa.byte_count); else n_pass++;
            tick();
        end
        ifa.block_ready = 1'b1;
        exp_blk = q_exp.pop_front();
        @(negedge clk);
        n_checks++; if (ifa.in_ready !== 1'b1) $display("FAIL bp_release_ready: got %b want 1", ifa.in_ready); else n_pass++;
        n_checks++; if (ifa.block_out !== exp_blk) $display("FAIL bp_release_block: got %h want %h", ifa.block_out, exp_blk); else n_pass++;
        tick();
        ifa.in_valid = 1'b0;
        @(negedge clk);
        n_checks++; if (ifa.block_valid !== 1'b0) $display("FAIL bp_after_valid: got %b want 0", ifa.block_valid); else n_pass++;
        n_checks++; if (ifa.byte_count !== 5'd1) $display("FAIL bp_after_count: got %0d want 1", ifa.byte_count); else n_pass++;
        n_checks++; if (ifa.block_out !== 128'hAA) $display("FAIL bp_after_lane0: got %h want aa", ifa.block_out); else n_pass++;
        tick();
    endtask

    task automatic test_msb_order();
        do_reset();
        exp_blk = '0;
        for (int i = 0; i < 16; i++) begin
            ifb.in_valid = 1'b1;
            ifb.in_byte  = 8'(i + 1);
            exp_blk[8*(15-i) +: 8] = 8'(i + 1);
            tick();
        end
        q_exp.push_back(exp_blk);
        ifb.in_valid = 1'b0;
        @(negedge clk);
        exp_blk = q_exp.pop_front();
        n_checks++; if (ifb.block_valid !== 1'b1) $display("FAIL msb_valid: got %b want 1", ifb.block_valid); else n_pass++;
        n_checks++; if (ifb.block_out !== exp_blk) $display("FAIL msb_block: got %h want %h", ifb.block_out, exp_blk); else n_pass++;
        tick();
    endtask

    task automatic test_flush();
        do_reset();
        ifa.block_ready = 1'b0;
        ifa.flush = 1'b1;
        tick();
        ifa.flush = 1'b0;
        @(negedge clk);
        n_checks++; if (ifa.block_valid !== 1'b0) $display("FAIL flush_empty_valid: got %b want 0", ifa.block_valid); else n_pass++;
        n_checks++; if (ifa.byte_count !== 5'd0) $display("FAIL flush_empty_count: got %0d want 0", ifa.byte_count); else n_pass++;
        tick();
        ifa.in_valid = 1'b1; ifa.in_byte = 8'h41; tick();
        ifa.in_byte = 8'h42; tick();
        ifa.in_valid = 1'b0; ifa.flush = 1'b1; tick();
        ifa.flush = 1'b0;
        @(negedge clk);
`ifdef BLOCK_ASM_FLUSH_EN
        q_exp.push_back({{14{8'h20}}, 8'h42, 8'h41});
        exp_blk = q_exp.pop_front();
        n_checks++; if (ifa.block_valid !== 1'b1) $display("FAIL flush_valid: got %b want 1", ifa.block_valid); else n_pass++;
        n_checks++; if (ifa.byte_count !== 5'd16) $display("FAIL flush_count: got %0d want 16", ifa.byte_count); else n_pass++;
        n_checks++; if (ifa.block_out !== exp_blk) $display("FAIL flush_block: got %h want %h", ifa.block_out, exp_blk); else n_pass++;
`else
        exp_blk = {112'h0, 8'h42, 8'h41};
        n_checks++; if (ifa.block_valid !== 1'b0) $display("FAIL flush_ignored_valid: got %b want 0", ifa.block_valid); else n_pass++;
        n_checks++; if (ifa.byte_count !== 5'd2) $display("FAIL flush_ignored_count: got %0d want 2", ifa.byte_count); else n_pass++;
        n_checks++; if (ifa.block_out !== exp_blk) $display("FAIL flush_ignored_lanes: got %h want %h", ifa.block_out, exp_blk); else n_pass++;
`endif
        tick();
    endtask

    task automatic test_reset_mid_block();
        do_reset();
        for (int i = 0; i < 7; i++) begin
            ifa.in_valid = 1'b1;
            ifa.in_byte  = 8'h30 + 8'(i);
            tick();
        end
        ifa.in_valid = 1'b0;
        rst = 1'b1;
        tick();
        rst = 1'b0;
        @(negedge clk);
        n_checks++; if (ifa.byte_count !== 5'd0) $display("FAIL midrst_count: got %0d want 0", ifa.byte_count); else n_pass++;
        n_checks++; if (ifa.block_out !== 128'h0) $display("FAIL midrst_out: got %h want 0", ifa.block_out); else n_pass++;
        n_checks++; if (ifa.block_valid !== 1'b0) $display("FAIL midrst_valid: got %b want 0", ifa.block_valid); else n_pass++;
        tick();
        exp_blk = '0;
        for (int i = 0; i < 16; i++) begin
            ifa.in_valid = 1'b1;
            ifa.in_byte  = 8'h80 + 8'(i);
            exp_blk[8*i +: 8] = 8'h80 + 8'(i);
            tick();
        end
        q_exp.push_back(exp_blk);
        ifa.in_valid = 1'b0;
        @(negedge clk);
        exp_blk = q_exp.pop_front();
        n_checks++; if (ifa.block_out !== exp_blk) $display("FAIL midrst_clean_block: got %h want %h", ifa.block_out, exp_blk); else n_pass++;
        tick();
    endtask

    task automatic test_random();
        logic [7:0]   m_lanes [16];
        int           m_count;
        bit           m_full;
        bit           m_ready;
        bit           fire_in;
        bit           fire_out;
        int           blocks;
        logic [127:0] blk;
        m_count = 0; m_full = 1'b0; blocks = 0;
        for (int k = 0; k < 16; k++) m_lanes[k] = 8'h00;
        do_reset();
        for (int c = 0; c < 10000; c++) begin
            if (!ifa.in_valid) begin
                ifa.in_valid = ($urandom_range(0, 3) != 0);
                ifa.in_byte  = 8'($urandom);
            end
            ifa.block_ready = 1'($urandom_range(0, 1));
            @(negedge clk);
            m_ready  = !m_full || ifa.block_ready;
            fire_in  = ifa.in_valid && m_ready;
            fire_out = m_full && ifa.block_ready;
            n_checks++; if (ifa.in_ready !== m_ready) $display("FAIL rnd_in_ready cyc%0d: got %b want %b", c, ifa.in_ready, m_ready); else n_pass++;
            n_checks++; if (ifa.block_valid !== m_full) $display("FAIL rnd_valid cyc%0d: got %b want %b", c, ifa.block_valid, m_full); else n_pass++;
            n_checks++; if (ifa.byte_count !== 5'(m_count)) $display("FAIL rnd_count cyc%0d: got %0d want %0d", c, ifa.byte_count, m_count); else n_pass++;
            if (m_full) begin
                n_checks++; if (ifa.block_out !== q_exp[0]) $display("FAIL rnd_block cyc%0d: got %h want %h", c, ifa.block_out, q_exp[0]); else n_pass++;
            end
            if (fire_out) begin
                void'(q_exp.pop_front());
                blocks++;
                m_count = 0;
            end
            if (fire_in) begin
                m_lanes[m_count] = ifa.in_byte;
                m_count++;
                if (m_count == 16) begin
                    for (int k = 0; k < 16; k++) blk[8*k +: 8] = m_lanes[k];
                    q_exp.push_back(blk);
                end
            end
            m_full = (m_count == 16);
            tick();
            if (fire_in) ifa.in_valid = 1'b0;
        end
        ifa.in_valid = 1'b0;
        n_checks++; if (blocks < 100) $display("FAIL rnd_throughput: got %0d blocks want >=100", blocks); else n_pass++;
    endtask

    initial begin
        test_reset();
        test_back_to_back();
        test_backpressure();
        test_msb_order();
        test_flush();
        test_reset_mid_block();
        test_random();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL timeout: simulation exceeded time limit");
        $fatal(1);
    end
endmodule
